// File: rtl/cw_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cw_sequencer
// Purpose  : Control-word sequencer for the LEGv8 datapath. A small loadable
//            program memory holds {control word, constant, last} entries that
//            are presented for exactly one clock each, free-running or
//            single-stepped, until a last-marked entry or the final slot.
// Ports    : clock/reset        rising-edge clock, async active-low reset
//            load_*             program-memory write port, load_err on reject
//            start/abort        run control (abort has priority)
//            step_mode/step     single-step selection (sampled at start)/advance
//            status             datapath flags (captured when enabled)
//            ControlWord/constant  registered entry outputs, 0 when idle
//            pc/busy/done       run progress
//            cap_addr/cap_status   status-capture readback
// Options  : CWSEQ_STATUS_CAPTURE_EN enables per-entry status capture.
// Revision : 1.0 - initial release
// ============================================================================
module cw_sequencer #(
    parameter int CW_WIDTH   = 25,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_we,
    input  logic [AW-1:0]         load_addr,
    input  logic [CW_WIDTH-1:0]   load_cw,
    input  logic [DATA_WIDTH-1:0] load_const,
    input  logic                  load_last,
    output logic                  load_err,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  step_mode,
    input  logic                  step,
    input  logic [3:0]            status,
    output logic [CW_WIDTH-1:0]   ControlWord,
    output logic [DATA_WIDTH-1:0] constant,
    output logic [AW-1:0]         pc,
    output logic                  busy,
    output logic                  done,
    input  logic [AW-1:0]         cap_addr,
    output logic [3:0]            cap_status
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Program memory (deliberately not reset so a reset keeps the program)
    logic [CW_WIDTH-1:0]   mem_cw    [DEPTH];
    logic [DATA_WIDTH-1:0] mem_const [DEPTH];
    logic [DEPTH-1:0]      mem_last;

    state_t          state;
    logic            step_mode_q;
    logic            load_ok;
    logic            at_end;
    logic [AW-1:0]   pc_next;

    // Writes are only safe while nothing is being presented and no run is
    // about to begin on the same edge.
    assign load_ok = load_we && !start && ((state == ST_IDLE) || (state == ST_DONE));
    // The DEPTH-1 bound stops the run even without a last marker, so pc never wraps.
    assign at_end  = mem_last[pc] || (pc == AW'(DEPTH - 1));
    assign pc_next = pc + AW'(1);

    always_ff @(posedge clock) begin
        if (load_ok) begin
            mem_cw[load_addr]    <= load_cw;
            mem_const[load_addr] <= load_const;
            mem_last[load_addr]  <= load_last;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            step_mode_q <= 1'b0;
            ControlWord <= '0;
            constant    <= '0;
            pc          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            load_err <= load_we && !load_ok;
            if (abort) begin
                state       <= ST_IDLE;
                ControlWord <= '0;
                constant    <= '0;
                pc          <= '0;
                busy        <= 1'b0;
                done        <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            state       <= ST_RUN;
                            step_mode_q <= step_mode;
                            ControlWord <= mem_cw[0];
                            constant    <= mem_const[0];
                            pc          <= '0;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        // Every presented entry lasts exactly one cycle.
                        if (at_end) begin
                            state       <= ST_DONE;
                            ControlWord <= '0;
                            constant    <= '0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                        end else if (step_mode_q) begin
                            state       <= ST_PAUSE;
                            ControlWord <= '0;
                            constant    <= '0;
                        end else begin
                            pc          <= pc_next;
                            ControlWord <= mem_cw[pc_next];
                            constant    <= mem_const[pc_next];
                        end
                    end
                    ST_PAUSE: begin
                        // PAUSE is only entered when the entry at pc was not
                        // the end of the program, so pc_next is in range.
                        if (step) begin
                            state       <= ST_RUN;
                            pc          <= pc_next;
                            ControlWord <= mem_cw[pc_next];
                            constant    <= mem_const[pc_next];
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef CWSEQ_STATUS_CAPTURE_EN
    logic [3:0] cap [DEPTH];

    // The edge that ends a presented entry is any edge seen while in RUN.
    always_ff @(posedge clock) begin
        if (state == ST_RUN) begin
            cap[pc] <= status;
        end
    end

    assign cap_status = cap[cap_addr];
`else
    logic unused_capture;

    assign cap_status     = 4'b0;
    assign unused_capture = &{1'b0, status, cap_addr};
`endif

endmodule
`default_nettype wire

// File: tb/tb_cw_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cw_sequencer
// Purpose  : Self-checking bench for cw_sequencer. Stimulus tasks describe
//            each run as a schedule of entries (one per cycle, pauses, done)
//            and publish the expected outputs; a compare process checks them
//            every cycle. Literal checks pin the schedule at key points.
// Options  : CWSEQ_STATUS_CAPTURE_EN enables the capture expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cw_sequencer;

    localparam int CW    = 25;
    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [CW-1:0] load_cw;
    logic [DW-1:0] load_const;
    logic          load_last;
    logic          load_err;
    logic          start;
    logic          abort;
    logic          step_mode;
    logic          step;
    logic [3:0]    status;
    logic [CW-1:0] ControlWord;
    logic [DW-1:0] constant;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic [AW-1:0] cap_addr = '0;
    logic [3:0]    cap_status;

    always #5 clock = ~clock;

    cw_sequencer #(.CW_WIDTH(CW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .load_we(load_we), .load_addr(load_addr), .load_cw(load_cw),
        .load_const(load_const), .load_last(load_last), .load_err(load_err),
        .start(start), .abort(abort), .step_mode(step_mode), .step(step),
        .status(status), .ControlWord(ControlWord), .constant(constant),
        .pc(pc), .busy(busy), .done(done),
        .cap_addr(cap_addr), .cap_status(cap_status)
    );

    // Program as the bench believes it was loaded
    logic [CW-1:0] p_cw    [DEPTH];
    logic [DW-1:0] p_const [DEPTH];
    bit            p_last  [DEPTH];
    logic [3:0]    m_cap   [DEPTH];
    bit            m_cap_v [DEPTH];
    int            salt = 0;

    // Expected outputs after the next rising edge
    logic [CW-1:0] e_cw = '0;
    logic [DW-1:0] e_const = '0;
    logic [AW-1:0] e_pc = '0;
    logic          e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
    bit            chk_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (chk_en) begin
            check("ControlWord", 64'(ControlWord), 64'(e_cw));
            check("constant", constant, e_const);
            check("pc", 64'(pc), 64'(e_pc));
            check("busy", 64'(busy), 64'(e_busy));
            check("done", 64'(done), 64'(e_done));
            check("load_err", 64'(load_err), 64'(e_err));
`ifdef CWSEQ_STATUS_CAPTURE_EN
            if (m_cap_v[cap_addr]) check("cap_status", 64'(cap_status), 64'(m_cap[cap_addr]));
`else
            check("cap_status_off", 64'(cap_status), 64'h0);
`endif
        end
    end

    // First entry that ends a run started at entry 0
    function automatic int find_end();
        for (int i = 0; i < DEPTH; i++) begin
            if (p_last[i] || i == DEPTH - 1) return i;
        end
        return DEPTH - 1;
    endfunction

    function automatic logic [3:0] pat(input int e);
        return 4'((e * 3 + salt) & 15);
    endfunction

    task automatic cycle();
        @(negedge clock);
        cap_addr = cap_addr + 4'd1;
    endtask

    task automatic clr();
        load_we = 1'b0; load_addr = '0; load_cw = '0; load_const = '0; load_last = 1'b0;
        start = 1'b0; abort = 1'b0; step_mode = 1'b0; step = 1'b0; status = 4'hF;
        e_err = 1'b0;
    endtask

    task automatic present(input int i);
        e_cw = p_cw[i]; e_const = p_const[i]; e_pc = AW'(i); e_busy = 1'b1; e_done = 1'b0;
    endtask

    task automatic zero_out();
        e_cw = '0; e_const = '0;
    endtask

    task automatic to_done(input int last);
        zero_out(); e_busy = 1'b0; e_done = 1'b1; e_pc = AW'(last);
    endtask

    // Status driven during the cycle whose closing edge ends entry e
    task automatic capture(input int e);
        status = pat(e); m_cap[e] = pat(e); m_cap_v[e] = 1'b1;
    endtask

    task automatic idle(input int n);
        clr();
        repeat (n) cycle();
    endtask

    task automatic load(input int a, input logic [CW-1:0] cw, input logic [DW-1:0] k, input bit last);
        clr();
        load_we = 1'b1; load_addr = AW'(a); load_cw = cw; load_const = k; load_last = last;
        p_cw[a] = cw; p_const[a] = k; p_last[a] = last;
        cycle();
        clr();
    endtask

    task automatic run_free();
        int last;
        last = find_end();
        clr();
        start = 1'b1;
        present(0);
        cycle();
        start = 1'b0;
        step_mode = 1'b1;   // only sampled at start
        step = 1'b1;        // ignored outside PAUSE
        for (int i = 1; i <= last; i++) begin
            capture(i - 1);
            present(i);
            cycle();
        end
        capture(last);
        to_done(last);
        cycle();
        clr();
    endtask

    task automatic run_step(input int gap);
        int last;
        int e;
        last = find_end();
        clr();
        start = 1'b1; step_mode = 1'b1;
        present(0);
        cycle();
        clr();
        e = 0;
        while (e <= last) begin
            capture(e);
            if (e == last) begin
                to_done(last);
                cycle();
                clr();
                break;
            end
            zero_out();
            cycle();
            status = 4'hF;
            start = 1'b1;   // ignored while busy
            cycle();
            start = 1'b0;
            repeat (gap - 3) cycle();
            step = 1'b1;
            present(e + 1);
            cycle();
            step = 1'b0;
            e++;
        end
    endtask

    task automatic load_demo();
        load(0, 25'h1F01641, 64'd4, 1'b0);
        load(1, 25'h0201645, 64'hDEAD_0001, 1'b0);
        load(2, 25'h1013A45, 64'hDEAD_0002, 1'b1);
    endtask

    initial begin
        clr();
        for (int i = 0; i < DEPTH; i++) begin
            p_last[i] = 1'b0; m_cap_v[i] = 1'b0;
        end
        @(negedge clock);
        check("rst_cw", 64'(ControlWord), 64'h0);
        check("rst_const", constant, 64'h0);
        check("rst_pc", 64'(pc), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_err", 64'(load_err), 64'h0);
        reset = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // Free-run of the three-entry demo program
        load_demo();
        run_free();
        check("free_pc_lit", 64'(pc), 64'd2);
        check("free_done_lit", 64'(done), 64'd1);
        check("free_cw_lit", 64'(ControlWord), 64'h0);
        idle(2);

        // Single-step, step pulses 5 cycles apart
        salt = 1;
        run_step(5);
        check("step_pc_lit", 64'(pc), 64'd2);
        check("step_done_lit", 64'(done), 64'd1);
        idle(2);

        // No last marker: stops at DEPTH-1
        for (int i = 0; i < DEPTH; i++) load(i, CW'(i * 37 + 5), {32'hC0DE, 32'(i)}, 1'b0);
        run_free();
        check("full_pc_lit", 64'(pc), 64'd15);
        check("full_done_lit", 64'(done), 64'd1);
        idle(2);

        // abort together with start during entry 1
        load_demo();
        salt = 4;
        clr(); start = 1'b1; present(0); cycle();
        clr(); capture(0); present(1); cycle();
        check("abort_entry1_cw_lit", 64'(ControlWord), 64'h0201645);
        check("abort_entry1_pc_lit", 64'(pc), 64'd1);
        abort = 1'b1; start = 1'b1; capture(1);
        zero_out(); e_pc = '0; e_busy = 1'b0; e_done = 1'b0;
        cycle();
        check("abort_busy_lit", 64'(busy), 64'd0);
        idle(2);

        // Rejected writes: during RUN, and together with start in DONE
        salt = 3;
        clr(); start = 1'b1; present(0); cycle();
        clr(); load_we = 1'b1; load_addr = 4'd1; load_cw = 25'h1FFFFFF; load_const = '1;
        capture(0); present(1); e_err = 1'b1; cycle();
        clr(); capture(1); present(2); cycle();
        clr(); capture(2); to_done(2); cycle();
        clr(); load_we = 1'b1; load_addr = 4'd2; load_cw = 25'h0000001; load_last = 1'b0;
        start = 1'b1; present(0); e_err = 1'b1; cycle();
        clr(); capture(0); present(1); cycle();
        clr(); capture(1); present(2); cycle();
        clr(); capture(2); to_done(2); cycle();
        idle(2);

        // Asynchronous reset during entry 2, then replay
        salt = 2;
        clr(); start = 1'b1; present(0); cycle();
        clr(); capture(0); present(1); cycle();
        clr(); capture(1); present(2); cycle();
        #2 reset = 1'b0;
        #1;
        check("areset_cw_lit", 64'(ControlWord), 64'h0);
        check("areset_const_lit", constant, 64'h0);
        check("areset_pc_lit", 64'(pc), 64'h0);
        check("areset_busy_lit", 64'(busy), 64'h0);
        zero_out(); e_pc = '0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
        cycle();
        reset = 1'b1;
        idle(1);
        run_free();
        check("replay_pc_lit", 64'(pc), 64'd2);
        check("replay_done_lit", 64'(done), 64'd1);
`ifdef CWSEQ_STATUS_CAPTURE_EN
        cap_addr = 4'd1;
        #1;
        check("cap1_lit", 64'(cap_status), 64'b0101);
`endif
        idle(3);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
